// File: rtl/drum_pkg.sv
// Shared types and elaboration helpers for the DRUM approximate divider.
package drum_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIN  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // One quotient bit per mantissa bit plus one per fractional bit appended.
    function automatic int iter_count(input int k, input int w);
        return k + w;
    endfunction

endpackage

// File: rtl/drum_div_reduce.sv
// Dynamic-range operand reduction: keep the leading one, K-2 following bits and a forced LSB.
module drum_div_reduce
    import drum_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int K     = 4,
    localparam int PW    = clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] x_i,
    output logic [K-1:0]     m_o,
    output logic [PW-1:0]    p_o
);

    logic [PW-1:0] ka;

    always_comb begin
        ka = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (x_i[i]) ka = PW'(i);
        end
        m_o = x_i[K-1:0];
        p_o = '0;
        // Shifting right by ka-K+2 leaves the leading one at bit K-2.
        if (ka >= PW'(K)) begin
            p_o = ka - PW'(K - 1);
            m_o = {(K-1)'(x_i >> (ka - PW'(K - 2))), 1'b1};
        end
    end

endmodule

// File: rtl/drum_div_u.sv
// Iterative approximate unsigned divider: reduced mantissas, restoring divide, realigning shift.
module drum_div_u
    import drum_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int K     = 4,
    localparam int PW    = clog2(WIDTH),
    localparam int ITER  = iter_count(K, WIDTH),
    localparam int CW    = clog2(ITER),
    localparam int SHW   = clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic             dbz
);

    div_state_e       state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] q_q;
    logic             dbz_q;
    logic [K+WIDTH-1:0] dvd_q, dvd_d;
    logic [K-1:0]     rem_q, rem_d;
    logic [K-1:0]     mb_q;
    logic [SHW-1:0]   sh_q, sh_d;
    logic [CW-1:0]    cnt_q;

    logic [K-1:0]     ma, mb;
    logic [PW-1:0]    pa, pb;
    logic [K:0]       rem_sh;
    logic             ge;

    drum_div_reduce #(.WIDTH(WIDTH), .K(K)) u_red_a (.x_i(a), .m_o(ma), .p_o(pa));
    drum_div_reduce #(.WIDTH(WIDTH), .K(K)) u_red_b (.x_i(b), .m_o(mb), .p_o(pb));

    // Modular arithmetic is safe: the true shift always lies in K..2*WIDTH-K.
    assign sh_d = SHW'(WIDTH) - SHW'(pa) + SHW'(pb);

    // Remainder after a successful subtract is below mb, so K bits hold it.
    always_comb begin
        rem_sh = {rem_q, dvd_q[K+WIDTH-1]};
        ge     = (rem_sh >= {1'b0, mb_q});
        rem_d  = ge ? (rem_sh[K-1:0] - mb_q) : rem_sh[K-1:0];
        dvd_d  = {dvd_q[K+WIDTH-2:0], ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            q_q         <= '0;
            dbz_q       <= 1'b0;
            dvd_q       <= '0;
            rem_q       <= '0;
            mb_q        <= '0;
            sh_q        <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        dvd_q      <= {ma, {WIDTH{1'b0}}};
                        rem_q      <= '0;
                        mb_q       <= mb;
                        sh_q       <= sh_d;
                        cnt_q      <= '0;
                        dbz_q      <= (b == '0);
                        state_q    <= (b == '0) ? FIN : DIV;
                    end
                end
                DIV: begin
                    dvd_q <= dvd_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(ITER - 1)) state_q <= FIN;
                end
                FIN: begin
                    q_q         <= dbz_q ? '1 : WIDTH'(dvd_q >> sh_q);
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign q         = q_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_drum_div_u.sv
// Scoreboard bench for drum_div_u: directed corner cases plus randomized traffic with stalls.
module tb_drum_div_u;

    localparam int W = 16;
    localparam int KM = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  q;
    logic          dbz;

    int            n_total = 0;
    int            n_bad   = 0;
    bit            rand_rdy = 0;
    logic [W:0]    sb[$];
    logic [W:0]    sb_exp;

    drum_div_u #(.WIDTH(W), .K(KM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: reduce each operand, divide mantissas exactly, shift back.
    function automatic logic [W:0] model(input logic [W-1:0] xa, input logic [W-1:0] xb);
        int      ka, kb, pa, pb, sh;
        longint  ma, mb, qm;
        if (xb == 0) return {1'b1, {W{1'b1}}};
        ka = 0;
        kb = 0;
        for (int i = 0; i < W; i++) begin
            if (xa[i]) ka = i;
            if (xb[i]) kb = i;
        end
        if (ka >= KM) begin
            pa = ka - KM + 1;
            ma = ((longint'(xa) >> (pa + 1)) << 1) | 1;
        end else begin
            pa = 0;
            ma = longint'(xa) % (1 << KM);
        end
        if (kb >= KM) begin
            pb = kb - KM + 1;
            mb = ((longint'(xb) >> (pb + 1)) << 1) | 1;
        end else begin
            pb = 0;
            mb = longint'(xb) % (1 << KM);
        end
        qm = (ma << W) / mb;
        sh = W - pa + pb;
        return {1'b0, W'(qm >> sh)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, output int lat);
        int n;
        in_valid = 1'b1;
        a = ta;
        b = tb_;
        n = 0;
        while (!in_ready && n < 300) begin
            tick();
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        sb.push_back(model(ta, tb_));
        tick();
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        lat = 0;
        while (!out_valid && lat < 300) begin
            tick();
            lat++;
        end
        if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                sb_exp = sb.pop_front();
                chk("sb_q", 32'(q), 32'(sb_exp[W-1:0]));
                chk("sb_dbz", 32'(dbz), 32'(sb_exp[W]));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_dbz", 32'(dbz), 32'd0);
        rst_n = 1'b1;
        tick();

        send(16'd100, 16'd7, lat);
        chk("t1_latency", 32'(lat), 32'd21);
        chk("t1_q", 32'(q), 32'd14);
        chk("t1_dbz", 32'(dbz), 32'd0);

        send(16'd12, 16'd3, lat);
        chk("t2_q_exact", 32'(q), 32'd4);
        send(16'd0, 16'd9, lat);
        chk("t2_q_zero", 32'(q), 32'd0);
        chk("t2_dbz_zero", 32'(dbz), 32'd0);
        send(16'hFFFF, 16'd1, lat);
        chk("t2_q_max", 32'(q), 32'd61440);

        send(16'd5, 16'd0, lat);
        chk("t3_latency", 32'(lat), 32'd1);
        chk("t3_q", 32'(q), 32'hFFFF);
        chk("t3_dbz", 32'(dbz), 32'd1);

        // Stalled output: results held, new requests ignored.
        tick();
        out_ready = 1'b0;
        send(16'd12, 16'd3, lat);
        in_valid = 1'b1;
        a = 16'd1;
        b = 16'd0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t4_stall_q", 32'(q), 32'd4);
            chk("t4_stall_dbz", 32'(dbz), 32'd0);
            chk("t4_stall_ov", 32'(out_valid), 32'd1);
            chk("t4_stall_ir", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("t4_release_ir", 32'(in_ready), 32'd1);
        chk("t4_release_ov", 32'(out_valid), 32'd0);
        tick();
        chk("t4_no_phantom_ov", 32'(out_valid), 32'd0);
        chk("t4_no_phantom_ir", 32'(in_ready), 32'd1);

        // Reset in the middle of a divide.
        in_valid = 1'b1;
        a = 16'd100;
        b = 16'd7;
        tick();
        in_valid = 1'b0;
        chk("t5_busy_ir", 32'(in_ready), 32'd0);
        for (int i = 0; i < 8; i++) tick();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ov", 32'(out_valid), 32'd0);
        chk("t5_rst_ir", 32'(in_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        send(16'd100, 16'd7, lat);
        chk("t5_after_latency", 32'(lat), 32'd21);
        chk("t5_after_q", 32'(q), 32'd14);

        // Random traffic with random consumer stalls.
        rand_rdy = 1;
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = W'($urandom_range(0, 15));
                1:       rb = W'($urandom_range(0, 255));
                default: rb = W'($urandom);
            endcase
            if (i == 5) rb = ra;
            send(ra, rb, lat);
        end
        rand_rdy  = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
